mux_rr_nx1: RTL and testbench
=============================

MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter DW, default 8: data width per channel, legal range 1..64.
REQ-003 SHALL use SW = max(1, clog2(N_CH)) as the select/grant width, derived and not overridable.
REQ-004 SHALL have one clock and a synchronous, active-high reset: `clk  in  1  rising-edge clock`.
REQ-005 SHALL have `rst  in  1  synchronous active-high reset`.
REQ-006 SHALL have `in_data  in  N_CH*DW  channel k occupies bits [k*DW +: DW]`.
REQ-007 SHALL have `in_valid  in  N_CH  per-channel data valid`.
REQ-008 SHALL have `in_ready  out  N_CH  per-channel accept; one-hot or zero`.
REQ-009 SHALL have `mode  in  1  0 = fixed select via sel, 1 = round-robin`.
REQ-010 SHALL have `sel  in  SW  channel index used when mode = 0`.
REQ-011 SHALL have `out_data  out  DW  registered selected data`.
REQ-012 SHALL have `out_valid  out  1  out_data holds an unconsumed word`.
REQ-013 SHALL have `out_ready  in  1  downstream accept`.
REQ-014 SHALL have `grant_id  out  SW  source channel of the word in out_data`.

Function
REQ-015 SHALL implement a one-entry output register with states EMPTY (out_valid = 0) and FULL (out_valid = 1).
- load = !out_valid | out_ready.
REQ-016 SHALL complete a transfer on channel k in any cycle where in_valid[k] & in_ready[k].
- Captures the word into out_data and k into grant_id at that edge.
- out_valid = 1 on the following cycle; accept-to-output latency is 1 cycle.
REQ-017 SHALL drive in_ready[k] = load & (k == candidate) & in_valid[k], computed combinationally.
- in_ready[k] never asserts for a non-valid channel.
REQ-018 SHALL select the candidate in mode 0 as sel.
- If sel >= N_CH, no channel is granted and all in_ready = 0.
REQ-019 SHALL select the candidate in mode 1 as the first valid channel scanning ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1 (wrap-around).
REQ-020 SHALL update ptr to (k+1) mod N_CH after each transfer from channel k; ptr SHALL be unchanged when no transfer occurs.
REQ-021 SHALL move FULL to EMPTY on out_ready & !transfer.
- FULL with out_ready & transfer stays FULL and loads the new word: back-to-back, no bubble.
REQ-022 SHALL hold out_data and grant_id stable while out_valid & !out_ready.
REQ-023 SHALL take effect of a change of mode or sel at the next arbitration.
- The word already in the output register is unaffected.
REQ-024 SHALL grant nothing and leave all state unchanged when no channel is valid.

Reset
REQ-025 SHALL on rst set out_valid = 0, out_data = 0, grant_id = 0 and ptr = 0.
REQ-026 SHALL force in_ready = 0 while rst is high.
REQ-027 SHALL discard any held word when rst is asserted mid-transfer.
- No transfer is counted or completed in a reset cycle.

Configuration
REQ-028 SHALL, with macro MUX_RR_NX1_STATS_EN defined, add ports:
- `xfer_cnt  out  16  transfers accepted since reset, saturating at 16'hFFFF`.
- `stall  out  1  out_valid & !out_ready`, registered.
- Both are 0 in reset.
REQ-029 SHALL, without MUX_RR_NX1_STATS_EN, omit those ports and all associated logic; behaviour is otherwise identical.

Verification
REQ-030 SHALL cover fixed mode: N_CH=4, DW=8, mode=0, sel=2, in_valid=4'b1111, data k=8'hA0+k, out_ready=1 -> out_data=8'hA2, grant_id=2 every cycle from cycle 2; in_ready=4'b0100.
REQ-031 SHALL cover round-robin: mode=1, all valid, out_ready=1 -> grant_id sequence 0,1,2,3,0,1 with no idle cycles.
REQ-032 SHALL cover skipping idle channels: mode=1, in_valid=4'b1010 -> grants alternate 1,3,1,3; ptr wraps 3 to 0 to select 1.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 3 cycles after the first load -> out_data/grant_id frozen, in_ready=0; on release, next word loads in the same cycle it is consumed.
REQ-034 SHALL cover reset and out-of-range select: assert rst while FULL -> out_valid=0, grant_id=0 next cycle; mode=0, sel=3 with N_CH=3 -> in_ready=0 indefinitely.
REQ-035 SHALL cover statistics: with MUX_RR_NX1_STATS_EN, 10 transfers -> xfer_cnt=10; counter preloaded via 65540 transfers -> xfer_cnt=16'hFFFF.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// N-to-1 valid/ready multiplexer with fixed or round-robin selection and a one-entry output register.
// Optional statistics ports (xfer_cnt, stall) are enabled by defining MUX_RR_NX1_STATS_EN.
module mux_rr_nx1 #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        grant_id
`ifdef MUX_RR_NX1_STATS_EN
    ,
    output logic [15:0]          xfer_cnt,
    output logic                 stall
`endif
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          xfer;
    logic [SW-1:0] cand;
    logic          cand_ok;
    logic [DW-1:0] cand_data;

    assign load = !valid_q || out_ready;

    // Fixed mode uses sel directly; round-robin takes the first valid channel at or after ptr.
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (!mode) begin
            if (int'(sel) < N_CH) begin
                cand    = sel;
                cand_ok = in_valid[sel];
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (in_valid[SW'((int'(ptr_q) + i) % N_CH)]) begin
                    cand    = SW'((int'(ptr_q) + i) % N_CH);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cand_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cand == SW'(k)) cand_data = in_data[k*DW +: DW];
        end
    end

    assign xfer = !rst && load && cand_ok;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[cand] = 1'b1;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = cand_data;
            grant_d = cand;
            valid_d = 1'b1;
            ptr_d   = SW'((int'(cand) + 1) % N_CH);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign grant_id  = grant_q;

`ifdef MUX_RR_NX1_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic        stall_q, stall_d;

    // Transfer counter saturates rather than wrapping.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (xfer && xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
        stall_d = valid_q && !out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign stall    = stall_q;
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1: directed scenarios plus randomized traffic against a
// behavioural model; a second N_CH=3 instance exercises the out-of-range fixed select.
module tb_mux_rr_nx1;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  grant_id;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  grant_id3;

`ifdef MUX_RR_NX1_STATS_EN
    logic [15:0] xfer_cnt, xfer_cnt3;
    logic        stall, stall3;
`endif

    always #5 clk = ~clk;

    mux_rr_nx1 #(.N_CH(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant_id(grant_id)
`ifdef MUX_RR_NX1_STATS_EN
        , .xfer_cnt(xfer_cnt), .stall(stall)
`endif
    );

    mux_rr_nx1 #(.N_CH(3), .DW(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(1'b0), .sel(2'd3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(1'b1), .grant_id(grant_id3)
`ifdef MUX_RR_NX1_STATS_EN
        , .xfer_cnt(xfer_cnt3), .stall(stall3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_valid = 0, m_data = 0, m_grant = 0, m_ptr = 0;
    int m_cnt = 0, m_stall = 0;
    int last_k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input bit m, input int s, input logic [3:0] v, input int p);
        if (!m) begin
            if (s < NCH && ((v >> s) & 4'd1) != 0) return s;
            return -1;
        end
        for (int o = 0; o < NCH; o++) begin
            if (((v >> ((p + o) % NCH)) & 4'd1) != 0) return (p + o) % NCH;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input bit m, input logic [1:0] s, input logic [3:0] v,
                        input bit ordy, input logic [31:0] d);
        int k;
        bit ld;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst = r; mode = m; sel = s; in_valid = v; out_ready = ordy; in_data = d;
        in_data3 = d[23:0]; in_valid3 = v[2:0];
        #1;
        k  = pick(m, int'(s), v, m_ptr);
        ld = (m_valid == 0) || ordy;
        exp_rdy = (!r && ld && k >= 0) ? (4'd1 << k) : 4'd0;
        check("in_ready", in_ready, exp_rdy);
        check("in_ready_n3_oob", in_ready3, 3'd0);
        @(posedge clk);
        last_k = -1;
        if (r) begin
            m_valid = 0; m_data = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
        end else begin
            m_stall = (m_valid != 0 && !ordy) ? 1 : 0;
            if (ld && k >= 0) begin
                m_data = int'((d >> (8 * k)) & 32'hFF);
                m_grant = k; m_valid = 1; m_ptr = (k + 1) % NCH;
                if (m_cnt < 65535) m_cnt++;
                last_k = k;
            end else if (ordy) begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", out_valid, m_valid[0]);
        check("out_data", out_data, m_data[7:0]);
        check("grant_id", grant_id, m_grant[1:0]);
        check("out_valid_n3", out_valid3, 1'b0);
`ifdef MUX_RR_NX1_STATS_EN
        check("xfer_cnt", xfer_cnt, m_cnt[15:0]);
        check("stall", stall, m_stall[0]);
`endif
    endtask

    localparam logic [31:0] PAT = 32'hA3A2A1A0;
    logic [7:0] frozen;
    int seq_rr[6] = '{0, 1, 2, 3, 0, 1};
    int seq_sk[4] = '{1, 3, 1, 3};

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
        in_data3 = '0; in_valid3 = '0;

        // Reset with all channels valid: nothing may be accepted
        step(1, 1, 2'd0, 4'b1111, 1, PAT);
        step(1, 0, 2'd2, 4'b1111, 1, PAT);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_grant", grant_id, 2'd0);

        // Fixed select sel=2
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2'd2, 4'b1111, 1, PAT);
            check("fixed_data", out_data, 8'hA2);
            check("fixed_grant", grant_id, 2'd2);
        end

        // Round-robin, all valid
        step(1, 1, 2'd0, 4'b1111, 1, PAT);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 2'd0, 4'b1111, 1, PAT);
            check("rr_seq", grant_id, seq_rr[i][1:0]);
        end

        // Round-robin skipping idle channels
        step(1, 1, 2'd0, 4'b1010, 1, PAT);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'd0, 4'b1010, 1, PAT);
            check("skip_seq", grant_id, seq_sk[i][1:0]);
        end

        // Backpressure: load once then stall three cycles
        step(1, 1, 2'd0, 4'b1111, 1, PAT);
        step(0, 1, 2'd0, 4'b1111, 1, PAT);
        frozen = out_data;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'd0, 4'b1111, 0, 32'h5A5A5A5A);
            check("bp_frozen", out_data, frozen);
        end
        step(0, 1, 2'd0, 4'b1111, 1, PAT);
        check("bp_release_load", out_valid, 1'b1);
        check("bp_release_grant", grant_id, 2'd1);

        // Reset while FULL discards the held word
        step(0, 1, 2'd0, 4'b1111, 0, PAT);
        step(1, 1, 2'd0, 4'b1111, 0, PAT);
        check("rst_full_valid", out_valid, 1'b0);
        check("rst_full_grant", grant_id, 2'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 60) == 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom);
        end

`ifdef MUX_RR_NX1_STATS_EN
        step(1, 1, 2'd0, 4'b1111, 1, PAT);
        for (int i = 0; i < 10; i++) step(0, 1, 2'd0, 4'b1111, 1, PAT);
        check("stats_10", xfer_cnt, 16'd10);
        for (int i = 0; i < 65530; i++) step(0, 1, 2'd0, 4'b1111, 1, PAT);
        check("stats_sat", xfer_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
